// File: rtl/mips_pkg.sv
// Shared MIPS-I definitions: opcodes, funct codes, REGIMM rt codes and the reset vector.
// Latency: n/a (constants, types and helpers only).
// Backpressure: n/a.
package mips_pkg;

    localparam logic [31:0] RESET_VECTOR_DEF = 32'hBFC0_0000;

    // Register indices with architectural meaning
    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_V0   = 5'd2;
    localparam logic [4:0] REG_RA   = 5'd31;

    // Primary opcodes
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    // SPECIAL funct codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // REGIMM rt codes
    localparam logic [4:0] RT_BLTZ = 5'd0;
    localparam logic [4:0] RT_BGEZ = 5'd1;

    // R-type field view of an instruction word; I/J fields overlay the low bits
    typedef struct packed {
        logic [5:0] opcode;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] shamt;
        logic [5:0] funct;
    } instr_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 GPR file: two asynchronous read ports, one synchronous write port, $2 tap.
// Latency: reads combinational; a write is visible right after the writing edge.
// Backpressure: none; caller qualifies wr_en (run/enable) itself. $0 never written.
module mips_regfile
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic [31:0] rs_dat,
    output logic [31:0] rt_dat,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_dat,
    output logic [31:0] v0_dat
);

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];

    always_comb begin
        regs_d = regs_q;
        if (wr_en && (wr_addr != REG_ZERO)) begin
            regs_d[wr_addr] = wr_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign rs_dat = (rs_addr == REG_ZERO) ? '0 : regs_q[rs_addr];
    assign rt_dat = (rt_addr == REG_ZERO) ? '0 : regs_q[rt_addr];
    assign v0_dat = regs_q[REG_V0];

endmodule

// File: rtl/mips_cpu_harvard_core.sv
// Single-cycle MIPS-I core, Harvard ports, branch delay slot, halts when PC reaches 0.
// Latency: one instruction per enabled rising edge; memories are combinational.
// Backpressure: clk_enable=0 freezes PC, GPRs and branch state; outputs follow held PC.
module mips_cpu_harvard_core
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    output logic        active,
    output logic [31:0] register_v0,
    input  logic        clk_enable,
    output logic [31:0] instr_address,
    input  logic [31:0] instr_readdata,
    output logic [31:0] data_address,
    output logic        data_write,
    output logic        data_read,
    output logic [31:0] data_writedata,
    input  logic [31:0] data_readdata
);

    logic [31:0] pc_q, pc_d;
    logic        pend_q, pend_d;   // a taken branch waits for its delay slot to finish
    logic [31:0] tgt_q, tgt_d;

    instr_t      ins;
    logic [31:0] simm, zimm, pc_plus4, pc_plus8, br_rel_target;
    logic [31:0] rs_dat, rt_dat, mem_addr;
    logic        run;

    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_dat;
    logic        is_lw, is_sw;
    logic        br_taken;
    logic [31:0] br_target;

    assign ins           = instr_t'(instr_readdata);
    assign simm          = sext16(instr_readdata[15:0]);
    assign zimm          = {16'd0, instr_readdata[15:0]};
    assign pc_plus4      = pc_q + 32'd4;
    assign pc_plus8      = pc_q + 32'd8;
    assign br_rel_target = pc_plus4 + {simm[29:0], 2'b00};
    assign mem_addr      = rs_dat + simm;

    // PC of 0 is the halt state; reset input gates active asynchronously
    assign active = reset && (pc_q != 32'd0);
    assign run    = active && clk_enable;

    mips_regfile u_regfile (
        .clk     (clk),
        .rst_n   (reset),
        .rs_addr (ins.rs),
        .rt_addr (ins.rt),
        .rs_dat  (rs_dat),
        .rt_dat  (rt_dat),
        .wr_en   (wr_en && run),
        .wr_addr (wr_addr),
        .wr_dat  (wr_dat),
        .v0_dat  (register_v0)
    );

    // Decode, ALU and branch resolution
    always_comb begin
        wr_en     = 1'b0;
        wr_addr   = ins.rt;
        wr_dat    = '0;
        is_lw     = 1'b0;
        is_sw     = 1'b0;
        br_taken  = 1'b0;
        br_target = br_rel_target;
        case (ins.opcode)
            OP_SPECIAL: begin
                wr_addr = ins.rd;
                wr_en   = 1'b1;
                case (ins.funct)
                    FN_SLL:  wr_dat = rt_dat << ins.shamt;
                    FN_SRL:  wr_dat = rt_dat >> ins.shamt;
                    FN_SRA:  wr_dat = 32'($signed(rt_dat) >>> ins.shamt);
                    FN_SLLV: wr_dat = rt_dat << rs_dat[4:0];
                    FN_SRLV: wr_dat = rt_dat >> rs_dat[4:0];
                    FN_SRAV: wr_dat = 32'($signed(rt_dat) >>> rs_dat[4:0]);
                    FN_ADDU: wr_dat = rs_dat + rt_dat;
                    FN_SUBU: wr_dat = rs_dat - rt_dat;
                    FN_AND:  wr_dat = rs_dat & rt_dat;
                    FN_OR:   wr_dat = rs_dat | rt_dat;
                    FN_XOR:  wr_dat = rs_dat ^ rt_dat;
                    FN_NOR:  wr_dat = ~(rs_dat | rt_dat);
                    FN_SLT:  wr_dat = {31'd0, $signed(rs_dat) < $signed(rt_dat)};
                    FN_SLTU: wr_dat = {31'd0, rs_dat < rt_dat};
                    FN_JR: begin
                        wr_en     = 1'b0;
                        br_taken  = 1'b1;
                        br_target = rs_dat;
                    end
                    FN_JALR: begin
                        br_taken  = 1'b1;
                        br_target = rs_dat;
                        wr_dat    = pc_plus8;
                    end
                    default: wr_en = 1'b0;
                endcase
            end
            OP_REGIMM: begin
                if (ins.rt == RT_BLTZ) br_taken = rs_dat[31];
                if (ins.rt == RT_BGEZ) br_taken = !rs_dat[31];
            end
            OP_J, OP_JAL: begin
                br_taken  = 1'b1;
                br_target = {pc_plus4[31:28], instr_readdata[25:0], 2'b00};
                if (ins.opcode == OP_JAL) begin
                    wr_en   = 1'b1;
                    wr_addr = REG_RA;
                    wr_dat  = pc_plus8;
                end
            end
            OP_BEQ:  br_taken = (rs_dat == rt_dat);
            OP_BNE:  br_taken = (rs_dat != rt_dat);
            OP_BLEZ: br_taken = rs_dat[31] || (rs_dat == 32'd0);
            OP_BGTZ: br_taken = !rs_dat[31] && (rs_dat != 32'd0);
            OP_ADDIU: begin wr_en = 1'b1; wr_dat = rs_dat + simm; end
            OP_SLTI:  begin wr_en = 1'b1; wr_dat = {31'd0, $signed(rs_dat) < $signed(simm)}; end
            OP_SLTIU: begin wr_en = 1'b1; wr_dat = {31'd0, rs_dat < simm}; end
            OP_ANDI:  begin wr_en = 1'b1; wr_dat = rs_dat & zimm; end
            OP_ORI:   begin wr_en = 1'b1; wr_dat = rs_dat | zimm; end
            OP_XORI:  begin wr_en = 1'b1; wr_dat = rs_dat ^ zimm; end
            OP_LUI:   begin wr_en = 1'b1; wr_dat = {instr_readdata[15:0], 16'd0}; end
            OP_LW: begin
                wr_en  = 1'b1;
                wr_dat = data_readdata;
                is_lw  = 1'b1;
            end
            OP_SW:   is_sw = 1'b1;
            default: ;
        endcase
    end

    // Next PC: a pending target wins over anything decoded in the delay slot,
    // so a branch sitting in a delay slot is ignored and the first target holds.
    always_comb begin
        pc_d   = pc_q;
        pend_d = pend_q;
        tgt_d  = tgt_q;
        if (run) begin
            if (pend_q) begin
                pc_d   = tgt_q;
                pend_d = 1'b0;
            end else begin
                pc_d = pc_plus4;
                if (br_taken) begin
                    pend_d = 1'b1;
                    tgt_d  = br_target;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q   <= RESET_VECTOR;
            pend_q <= 1'b0;
            tgt_q  <= '0;
        end else begin
            pc_q   <= pc_d;
            pend_q <= pend_d;
            tgt_q  <= tgt_d;
        end
    end

    assign instr_address  = pc_q;
    assign data_address   = mem_addr;
    assign data_writedata = rt_dat;
    assign data_read      = is_lw && active;
    assign data_write     = is_sw && active;

endmodule

// File: tb/tb_mips_cpu_harvard_core.sv
module tb_mips_cpu_harvard_core;

    localparam logic [31:0] BASE = 32'hBFC0_0000;

    localparam logic [5:0] O_SP = 6'h00, O_RI = 6'h01, O_JAL = 6'h03;
    localparam logic [5:0] O_BEQ = 6'h04, O_BNE = 6'h05;
    localparam logic [5:0] O_ADDIU = 6'h09, O_SLTI = 6'h0A, O_SLTIU = 6'h0B;
    localparam logic [5:0] O_ANDI = 6'h0C, O_ORI = 6'h0D, O_XORI = 6'h0E, O_LUI = 6'h0F;
    localparam logic [5:0] O_LW = 6'h23, O_SW = 6'h2B;
    localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06, F_SRAV = 6'h07, F_JR = 6'h08;
    localparam logic [5:0] F_ADDU = 6'h21, F_SUBU = 6'h23, F_OR = 6'h25, F_XOR = 6'h26;
    localparam logic [5:0] F_NOR = 6'h27, F_SLT = 6'h2A, F_SLTU = 6'h2B;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clk_enable = 1'b1;
    logic        active;
    logic [31:0] register_v0;
    logic [31:0] instr_address;
    logic [31:0] instr_readdata;
    logic [31:0] data_address;
    logic        data_write;
    logic        data_read;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;

    logic [31:0] rom [16];
    logic [31:0] dmem [64];
    logic [31:0] rom_off;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mips_cpu_harvard_core dut (
        .clk            (clk),
        .reset          (reset),
        .active         (active),
        .register_v0    (register_v0),
        .clk_enable     (clk_enable),
        .instr_address  (instr_address),
        .instr_readdata (instr_readdata),
        .data_address   (data_address),
        .data_write     (data_write),
        .data_read      (data_read),
        .data_writedata (data_writedata),
        .data_readdata  (data_readdata)
    );

    // Instruction ROM mapped at BASE; everything else reads as NOP
    always_comb begin
        rom_off        = instr_address - BASE;
        instr_readdata = 32'd0;
        if (rom_off < 32'd64) instr_readdata = rom[rom_off[5:2]];
    end

    assign data_readdata = dmem[data_address[7:2]];
    always @(posedge clk) begin
        if (data_write && clk_enable) dmem[data_address[7:2]] <= data_writedata;
    end

    function automatic logic [31:0] ei(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] er(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [4:0] sh,
                                       input logic [5:0] fn);
        return {6'd0, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] ej(input logic [5:0] op, input logic [31:0] tgt);
        return {op, tgt[27:2]};
    endfunction

    typedef struct packed {
        logic [15:0][31:0] prog;
        logic [31:0]       exp_v0;
        logic [7:0]        exp_st;
        logic [7:0]        exp_ld;
        logic [31:0]       exp_st_addr;
        logic [31:0]       exp_st_dat;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic start(input vec_t v);
        @(negedge clk);
        reset      = 1'b0;
        clk_enable = 1'b1;
        for (int i = 0; i < 16; i++) rom[i] = v.prog[i];
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Runs from a negedge until active drops; records memory strobes per cycle
    task automatic run_halt(input int budget, output logic ok, output int st, output int ld,
                            output logic [31:0] sa, output logic [31:0] sd);
        ok = 1'b0; st = 0; ld = 0; sa = '0; sd = '0;
        for (int c = 0; c < budget; c++) begin
            #1;
            if (!active) begin
                ok = 1'b1;
                break;
            end
            if (data_write) begin
                st++;
                sa = data_address;
                sd = data_writedata;
            end
            if (data_read) ld++;
            @(negedge clk);
        end
    endtask

    initial begin
        logic        ok;
        int          st, ld, errs;
        logic [31:0] sa, sd;

        for (int k = 0; k < 5; k++) vecs[k] = '0;

        // BGEZ not-taken / taken with delay slots
        vecs[0].prog[0]  = ei(O_ADDIU, 0, 1, 16'd32);
        vecs[0].prog[1]  = er(0, 1, 3, 0, F_SUBU);
        vecs[0].prog[2]  = ei(O_RI, 3, 1, 16'd3);
        vecs[0].prog[3]  = ei(O_ADDIU, 0, 2, 16'd32);
        vecs[0].prog[4]  = ei(O_RI, 1, 1, 16'd2);
        vecs[0].prog[5]  = ei(O_ADDIU, 2, 2, 16'd32);
        vecs[0].prog[6]  = ei(O_ADDIU, 2, 2, 16'd1000);
        vecs[0].prog[7]  = ei(O_RI, 0, 1, 16'd2);
        vecs[0].prog[8]  = ei(O_ADDIU, 2, 2, 16'd32);
        vecs[0].prog[9]  = ei(O_ADDIU, 2, 2, 16'd1000);
        vecs[0].prog[10] = ei(O_ADDIU, 2, 2, 16'd32);
        vecs[0].prog[11] = er(0, 0, 0, 0, F_JR);
        vecs[0].exp_v0   = 32'd128;

        // Store then load back
        vecs[1].prog[0] = ei(O_ADDIU, 0, 4, 16'h0010);
        vecs[1].prog[1] = ei(O_LUI, 0, 5, 16'hDEAD);
        vecs[1].prog[2] = ei(O_ORI, 5, 5, 16'hBEEF);
        vecs[1].prog[3] = ei(O_SW, 4, 5, 16'd0);
        vecs[1].prog[4] = ei(O_LW, 4, 2, 16'd0);
        vecs[1].prog[5] = er(0, 0, 0, 0, F_JR);
        vecs[1].exp_v0      = 32'hDEAD_BEEF;
        vecs[1].exp_st      = 8'd1;
        vecs[1].exp_ld      = 8'd1;
        vecs[1].exp_st_addr = 32'h0000_0010;
        vecs[1].exp_st_dat  = 32'hDEAD_BEEF;

        // BNE not taken, BLTZ taken, BNE taken; skipped adds must not land
        vecs[2].prog[0]  = ei(O_ADDIU, 0, 3, 16'hFFFF);
        vecs[2].prog[1]  = ei(O_ADDIU, 0, 2, 16'd5);
        vecs[2].prog[2]  = ei(O_BNE, 3, 3, 16'd5);
        vecs[2].prog[3]  = ei(O_ADDIU, 2, 2, 16'd1);
        vecs[2].prog[4]  = ei(O_RI, 3, 0, 16'd2);
        vecs[2].prog[5]  = ei(O_ADDIU, 2, 2, 16'd16);
        vecs[2].prog[6]  = ei(O_ADDIU, 2, 2, 16'd256);
        vecs[2].prog[7]  = ei(O_BNE, 3, 0, 16'd2);
        vecs[2].prog[8]  = ei(O_ADDIU, 2, 2, 16'd100);
        vecs[2].prog[9]  = ei(O_ADDIU, 2, 2, 16'd512);
        vecs[2].prog[10] = er(0, 0, 0, 0, F_JR);
        vecs[2].exp_v0   = 32'd122;

        // JAL into a subroutine that copies $31
        vecs[3].prog[0] = ei(O_ADDIU, 0, 2, 16'd7);
        vecs[3].prog[1] = ej(O_JAL, BASE + 32'h10);
        vecs[3].prog[3] = ei(O_ADDIU, 0, 2, 16'd99);
        vecs[3].prog[4] = er(31, 0, 2, 0, F_ADDU);
        vecs[3].prog[5] = er(0, 0, 0, 0, F_JR);
        vecs[3].exp_v0  = 32'hBFC0_000C;

        // Logical immediates, fixed shifts, signed/unsigned compares
        vecs[4].prog[0]  = ei(O_ADDIU, 0, 1, 16'hF0F0);
        vecs[4].prog[1]  = ei(O_ANDI, 1, 2, 16'hFF00);
        vecs[4].prog[2]  = ei(O_XORI, 2, 2, 16'h8001);
        vecs[4].prog[3]  = er(0, 2, 2, 4, F_SLL);
        vecs[4].prog[4]  = er(0, 1, 6, 4, F_SRA);
        vecs[4].prog[5]  = er(0, 1, 7, 28, F_SRL);
        vecs[4].prog[6]  = er(2, 7, 2, 0, F_ADDU);
        vecs[4].prog[7]  = er(6, 7, 8, 0, F_SLT);
        vecs[4].prog[8]  = er(6, 7, 9, 0, F_SLTU);
        vecs[4].prog[9]  = er(2, 8, 2, 0, F_ADDU);
        vecs[4].prog[10] = er(2, 9, 2, 0, F_ADDU);
        vecs[4].prog[11] = er(0, 0, 10, 0, F_NOR);
        vecs[4].prog[12] = er(2, 10, 2, 0, F_SUBU);
        vecs[4].prog[13] = er(0, 0, 0, 0, F_JR);
        vecs[4].exp_v0   = 32'h0007_0021;

        // Reset state, with a SW at the reset vector to expose ungated strobes
        for (int i = 0; i < 16; i++) rom[i] = 32'd0;
        rom[0] = ei(O_SW, 0, 0, 16'h0020);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_pc", instr_address, 32'hBFC0_0000);
        chk("rst_active", {31'd0, active}, 32'd0);
        chk("rst_v0", register_v0, 32'd0);
        chk("rst_dwrite", {31'd0, data_write}, 32'd0);
        chk("rst_dread", {31'd0, data_read}, 32'd0);
        reset = 1'b1;
        #1;
        chk("first_fetch", instr_address, 32'hBFC0_0000);
        chk("first_active", {31'd0, active}, 32'd1);
        chk("first_sw_strobe", {31'd0, data_write}, 32'd1);
        @(negedge clk);
        #1;
        chk("second_fetch", instr_address, 32'hBFC0_0004);

        // Table of whole programs, each checked at halt
        for (int k = 0; k < 5; k++) begin
            start(vecs[k]);
            run_halt(300, ok, st, ld, sa, sd);
            chk($sformatf("v%0d_halted", k), {31'd0, ok}, 32'd1);
            chk($sformatf("v%0d_v0", k), register_v0, vecs[k].exp_v0);
            chk($sformatf("v%0d_pc0", k), instr_address, 32'd0);
            chk($sformatf("v%0d_stores", k), st, {24'd0, vecs[k].exp_st});
            chk($sformatf("v%0d_loads", k), ld, {24'd0, vecs[k].exp_ld});
            chk($sformatf("v%0d_st_addr", k), sa, vecs[k].exp_st_addr);
            chk($sformatf("v%0d_st_dat", k), sd, vecs[k].exp_st_dat);
        end

        // clk_enable freeze in the middle of the BGEZ program
        start(vecs[0]);
        repeat (4) @(negedge clk);
        clk_enable = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        chk("freeze_pc", instr_address, 32'hBFC0_0010);
        chk("freeze_v0", register_v0, 32'd32);
        chk("freeze_active", {31'd0, active}, 32'd1);
        @(negedge clk);
        clk_enable = 1'b1;
        run_halt(300, ok, st, ld, sa, sd);
        chk("freeze_halted", {31'd0, ok}, 32'd1);
        chk("freeze_v0_end", register_v0, 32'd128);

        // Post-halt hold for 20 cycles
        errs = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1;
            if (active || instr_address != 32'd0 || register_v0 != 32'd128 ||
                data_write || data_read) errs++;
        end
        chk("halt_hold_cycles", errs, 32'd0);

        // Async reset while a taken branch is pending; the branch must be dropped
        start(vecs[0]);
        repeat (5) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_pc", instr_address, 32'hBFC0_0000);
        chk("midrst_v0", register_v0, 32'd0);
        chk("midrst_active", {31'd0, active}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        run_halt(300, ok, st, ld, sa, sd);
        chk("midrst_halted", {31'd0, ok}, 32'd1);
        chk("midrst_v0_end", register_v0, 32'd128);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
